chisq_seq_ctrl: RTL and testbench
=================================

# chisq_seq_ctrl

Parametrised phase sequencer for the chi-square unit of the fitter datapath. Steps the chi-square multiplexer through NPHASE term-selection phases per track, drives the accumulator clear/last strobes, and emits a done strobe carrying the track tag after the datapath pipeline latency. Supports back-to-back tracks, a one-deep pending-start buffer, abort, and sticky overrun detection.

## Interface
- NPHASE, 3, phases per track (2..16)
- SEL_W, 2, mux select width; 2^SEL_W > NPHASE is required so the all-ones idle code is never a valid phase
- PIPE_LAT, 4, cycles from the acc_last cycle to the accumulator result valid (1..32)
- TAG_W, 8, track tag width
- clock  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  request one chi-square sequence
- start_tag  in  TAG_W  tag sampled with start
- abort  in  1  synchronous abort of the current and pending sequences
- mux  out  SEL_W  phase select; all-ones when idle
- mux_valid  out  1  mux holds a valid phase
- acc_clear  out  1  high during phase 0
- acc_last  out  1  high during phase NPHASE-1
- ready  out  1  start will be accepted (= not pending)
- busy  out  1  RUN state or pending set
- done  out  1  one-cycle strobe: accumulator result valid
- done_tag  out  TAG_W  tag of the finished track, valid with done
- overrun  out  1  sticky: a start was dropped

## Operation
- States: IDLE, RUN. Phase counter ph (0..NPHASE-1) is used only in RUN.
- IDLE: mux = all ones, mux_valid=0. start=1 -> RUN with ph=0; active_tag <= start_tag.
- RUN: mux=ph, mux_valid=1, acc_clear=(ph==0), acc_last=(ph==NPHASE-1). ph increments each cycle.
- At ph==NPHASE-1:
  - pending set -> ph=0, active_tag <= pend_tag, pending cleared.
  - else start=1 -> ph=0, active_tag <= start_tag (direct back-to-back, no bubble).
  - else -> IDLE.
- start in RUN with ph!=NPHASE-1 and pending clear: pending <= 1, pend_tag <= start_tag.
- start while ready=0: dropped, overrun <= 1. overrun is cleared only by reset.
- start at the last phase while pending is set: ready=0, so the start is dropped and overrun is set.
- Done pipeline: a PIPE_LAT-deep shift register of {acc_last, active_tag}. done and done_tag are the last stage.
- abort=1: next cycle IDLE, pending cleared, done pipeline flushed (in-flight tracks produce no done), overrun unchanged. abort overrides a simultaneous start; that start is neither accepted nor counted as overrun.
- Reset values: mux all ones, mux_valid=0, acc_clear=0, acc_last=0, ready=1, busy=0, done=0, done_tag=0, overrun=0, pending=0, pipeline cleared.
- Reset mid-sequence has the same effect as abort, and also clears overrun.
- With defaults, NPHASE=3 / SEL_W=2 gives phase codes 00/01/10 and idle code 11.

## Timing
- start sampled at cycle t in IDLE: mux=0 at t+1, acc_last at t+NPHASE, done at t+NPHASE+PIPE_LAT.
- Throughput: one track per NPHASE cycles when start or pending is present at each last phase.
- All outputs are registered, or decoded from registered state only. No combinational path from start or abort to any output.
- done is exactly one cycle wide per completed track, and done strobes keep the same order as the tracks.

## Test plan
- Reset, then start=1 for one cycle with tag 0x5A at cycle 10: mux 11->00(11),01(12),10(13)->11; acc_clear at 11; acc_last at 13; done=1 with done_tag=0x5A at 17 only.
- start held high with tags 1,2,3 on successive last-phase cycles: mux repeats 00,01,10 with no idle code; done at 17,20,23 with tags 1,2,3.
- start (tag 0x10) at cycle 10, start (tag 0x20) at 12: pending captured, ready=0 at 13, second run starts at 14; done tags 0x10@17, 0x20@20; overrun=0.
- Third start at 13 while pending is set: dropped, overrun=1 and stays 1; only two done strobes.
- abort at 12 during a run with pending set: IDLE at 13, mux=11, busy=0, no done for either track; a following start works normally.
- abort and start in the same IDLE cycle: state stays IDLE, no run, overrun unchanged. Repeat with NPHASE=5, SEL_W=3, PIPE_LAT=1: phases 0..4, idle code 111, done 6 cycles after start.

Source files
------------

// File: rtl/chisq_seq_ctrl.sv
// chisq_seq_ctrl: phase sequencer for the chi-square unit.
// Walks the chi-square mux through NPHASE term-select phases per track,
// drives the accumulator clear/last strobes and returns a done strobe with
// the track tag PIPE_LAT cycles after the last phase. Holds one pending
// start so back-to-back tracks run without an idle bubble.
module chisq_seq_ctrl #(
  parameter int NPHASE   = 3,
  parameter int SEL_W    = 2,
  parameter int PIPE_LAT = 4,
  parameter int TAG_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [TAG_W-1:0] start_tag,
  input  logic             abort,
  output logic [SEL_W-1:0] mux,
  output logic             mux_valid,
  output logic             acc_clear,
  output logic             acc_last,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [TAG_W-1:0] done_tag,
  output logic             overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [SEL_W-1:0] LAST_PH   = SEL_W'(NPHASE - 1);
  localparam logic [SEL_W-1:0] IDLE_CODE = '1;

  logic [0:0]       state;
  logic [SEL_W-1:0] ph;
  logic [TAG_W-1:0] active_tag;
  logic             pending;
  logic [TAG_W-1:0] pend_tag;
  logic             ovr_q;
  logic             running;
  logic             at_last;

  logic [PIPE_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]    pipe_tag [PIPE_LAT];

  assign running = (state == RUN);
  assign at_last = running && (ph == LAST_PH);

  assign mux       = running ? ph : IDLE_CODE;
  assign mux_valid = running;
  assign acc_clear = running && (ph == '0);
  assign acc_last  = at_last;
  assign ready     = !pending;
  assign busy      = running || pending;
  assign done      = pipe_vld[PIPE_LAT-1];
  assign done_tag  = pipe_tag[PIPE_LAT-1];
  assign overrun   = ovr_q;

  // Phase sequencing, pending-start buffer and sticky overrun flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ph         <= '0;
      active_tag <= '0;
      pending    <= 1'b0;
      pend_tag   <= '0;
      ovr_q      <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      ph      <= '0;
      pending <= 1'b0;
    end else begin
      if (start && pending) begin
        ovr_q <= 1'b1;
      end
      if (state == IDLE) begin
        if (start) begin
          state      <= RUN;
          ph         <= '0;
          active_tag <= start_tag;
        end
      end else if (ph == LAST_PH) begin
        if (pending) begin
          ph         <= '0;
          active_tag <= pend_tag;
          pending    <= 1'b0;
        end else if (start) begin
          ph         <= '0;
          active_tag <= start_tag;
        end else begin
          state <= IDLE;
          ph    <= '0;
        end
      end else begin
        ph <= ph + SEL_W'(1);
        if (start && !pending) begin
          pending  <= 1'b1;
          pend_tag <= start_tag;
        end
      end
    end
  end

  // Delay line matching the datapath latency; abort drops in-flight tracks.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      pipe_vld <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= at_last;
      pipe_tag[0] <= at_last ? active_tag : '0;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

endmodule

// File: tb/tb_chisq_seq_ctrl.sv
// tb_chisq_seq_ctrl: directed bench for chisq_seq_ctrl.
// One instance with default parameters, one with NPHASE=5/SEL_W=3/PIPE_LAT=1.
// Inputs change 1ns after posedge, outputs are sampled on the negedge.
module tb_chisq_seq_ctrl;

  typedef struct {
    logic       s;
    logic [7:0] tag;
    logic       a;
    logic [1:0] mux;
    logic       mv;
    logic       clr;
    logic       last;
    logic       rdy;
    logic       busy;
    logic       done;
    logic [7:0] dtag;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [7:0] start_tag;
  logic [1:0] mux;
  logic       mux_valid, acc_clear, acc_last, ready, busy, done, overrun;
  logic [7:0] done_tag;

  logic       start5, abort5;
  logic [7:0] start_tag5;
  logic [2:0] mux5;
  logic       mux_valid5, acc_clear5, acc_last5, ready5, busy5, done5, overrun5;
  logic [7:0] done_tag5;

  int errors = 0;
  int checks = 0;
  int target = 0;
  vec_t tbl[$];

  chisq_seq_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .start_tag(start_tag), .abort(abort),
    .mux(mux), .mux_valid(mux_valid), .acc_clear(acc_clear), .acc_last(acc_last),
    .ready(ready), .busy(busy), .done(done), .done_tag(done_tag), .overrun(overrun)
  );

  chisq_seq_ctrl #(.NPHASE(5), .SEL_W(3), .PIPE_LAT(1), .TAG_W(8)) dut5 (
    .clock(clock), .reset(reset), .start(start5), .start_tag(start_tag5), .abort(abort5),
    .mux(mux5), .mux_valid(mux_valid5), .acc_clear(acc_clear5), .acc_last(acc_last5),
    .ready(ready5), .busy(busy5), .done(done5), .done_tag(done_tag5), .overrun(overrun5)
  );

  // Free-running 10ns clock.
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic s, input logic [7:0] tag, input logic a,
                              input logic [1:0] m, input logic mv, input logic clr,
                              input logic last, input logic rdy, input logic bsy,
                              input logic dn, input logic [7:0] dtag);
    vec_t v;
    v.s = s; v.tag = tag; v.a = a; v.mux = m; v.mv = mv; v.clr = clr;
    v.last = last; v.rdy = rdy; v.busy = bsy; v.done = dn; v.dtag = dtag;
    return v;
  endfunction

  // Drive one cycle of inputs to the selected instance, then wait for the sample point.
  task automatic applyStimulus(input logic s, input logic [7:0] tag, input logic a);
    start      = (target == 0) ? s : 1'b0;
    start_tag  = (target == 0) ? tag : 8'h00;
    abort      = (target == 0) ? a : 1'b0;
    start5     = (target == 1) ? s : 1'b0;
    start_tag5 = (target == 1) ? tag : 8'h00;
    abort5     = (target == 1) ? a : 1'b0;
    @(negedge clock);
  endtask

  task automatic endCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    int dcount;

    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    endCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst.mux", int'(mux), 3);
    checkOutput("rst.mux_valid", int'(mux_valid), 0);
    checkOutput("rst.acc_clear", int'(acc_clear), 0);
    checkOutput("rst.acc_last", int'(acc_last), 0);
    checkOutput("rst.ready", int'(ready), 1);
    checkOutput("rst.busy", int'(busy), 0);
    checkOutput("rst.done", int'(done), 0);
    checkOutput("rst.done_tag", int'(done_tag), 0);
    checkOutput("rst.overrun", int'(overrun), 0);
    checkOutput("rst.mux5", int'(mux5), 7);
    endCycle();
    reset = 1'b0;

    // Single track with tag 5A, then three back-to-back tracks tagged 1,2,3.
    tbl.push_back(mk(1, 8'h5A, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 1, 8'h5A));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h01, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h02, 0, 2, 1, 0, 1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h03, 0, 2, 1, 0, 1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 1, 8'h01));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 1, 1, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 1, 8'h02));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 1, 8'h03));
    tbl.push_back(mk(0, 8'h00, 0, 3, 0, 0, 0, 1, 0, 0, 8'h00));

    target = 0;
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].s, tbl[i].tag, tbl[i].a);
      checkOutput($sformatf("tbl[%0d].mux", i), int'(mux), int'(tbl[i].mux));
      checkOutput($sformatf("tbl[%0d].mux_valid", i), int'(mux_valid), int'(tbl[i].mv));
      checkOutput($sformatf("tbl[%0d].acc_clear", i), int'(acc_clear), int'(tbl[i].clr));
      checkOutput($sformatf("tbl[%0d].acc_last", i), int'(acc_last), int'(tbl[i].last));
      checkOutput($sformatf("tbl[%0d].ready", i), int'(ready), int'(tbl[i].rdy));
      checkOutput($sformatf("tbl[%0d].busy", i), int'(busy), int'(tbl[i].busy));
      checkOutput($sformatf("tbl[%0d].done", i), int'(done), int'(tbl[i].done));
      checkOutput($sformatf("tbl[%0d].done_tag", i), int'(done_tag), int'(tbl[i].dtag));
      checkOutput($sformatf("tbl[%0d].overrun", i), int'(overrun), 0);
      endCycle();
    end

    // Pending capture; second pass adds a third start while pending is set.
    for (int third = 0; third < 2; third++) begin
      dcount = 0;
      for (int r = 0; r < 14; r++) begin
        if (r == 0) applyStimulus(1'b1, 8'h10, 1'b0);
        else if (r == 2) applyStimulus(1'b1, 8'h20, 1'b0);
        else if (r == 3 && third == 1) applyStimulus(1'b1, 8'h30, 1'b0);
        else applyStimulus(1'b0, 8'h00, 1'b0);
        if (done) dcount++;
        if (r == 3) begin
          checkOutput($sformatf("pend%0d.ready@3", third), int'(ready), 0);
          checkOutput($sformatf("pend%0d.busy@3", third), int'(busy), 1);
        end
        if (r == 4) begin
          checkOutput($sformatf("pend%0d.mux@4", third), int'(mux), 0);
          checkOutput($sformatf("pend%0d.ready@4", third), int'(ready), 1);
          checkOutput($sformatf("pend%0d.overrun@4", third), int'(overrun), third);
        end
        if (r == 7) begin
          checkOutput($sformatf("pend%0d.mux@7", third), int'(mux), 3);
          checkOutput($sformatf("pend%0d.done@7", third), int'(done), 1);
          checkOutput($sformatf("pend%0d.done_tag@7", third), int'(done_tag), 8'h10);
        end
        if (r == 10) begin
          checkOutput($sformatf("pend%0d.done@10", third), int'(done), 1);
          checkOutput($sformatf("pend%0d.done_tag@10", third), int'(done_tag), 8'h20);
        end
        endCycle();
      end
      checkOutput($sformatf("pend%0d.done_count", third), dcount, 2);
      checkOutput($sformatf("pend%0d.overrun_end", third), int'(overrun), third);
    end

    // Abort with pending set (cycle 2) and after the first track's last phase (cycle 4).
    for (int k = 0; k < 2; k++) begin
      int abortAt;
      abortAt = (k == 0) ? 2 : 4;
      dcount = 0;
      for (int r = 0; r < 16; r++) begin
        if (r == 0) applyStimulus(1'b1, 8'hA1, 1'b0);
        else if (r == 1) applyStimulus(1'b1, 8'hB2, 1'b0);
        else if (r == abortAt) applyStimulus(1'b0, 8'h00, 1'b1);
        else applyStimulus(1'b0, 8'h00, 1'b0);
        if (done) dcount++;
        if (r == abortAt + 1) begin
          checkOutput($sformatf("abort%0d.mux", abortAt), int'(mux), 3);
          checkOutput($sformatf("abort%0d.mux_valid", abortAt), int'(mux_valid), 0);
          checkOutput($sformatf("abort%0d.busy", abortAt), int'(busy), 0);
          checkOutput($sformatf("abort%0d.ready", abortAt), int'(ready), 1);
        end
        endCycle();
      end
      checkOutput($sformatf("abort%0d.done_count", abortAt), dcount, 0);
      checkOutput($sformatf("abort%0d.overrun", abortAt), int'(overrun), 1);
    end

    // Start after abort behaves normally.
    for (int r = 0; r < 9; r++) begin
      applyStimulus(r == 0, 8'h77, 1'b0);
      if (r == 1) checkOutput("post_abort.mux@1", int'(mux), 0);
      if (r == 3) checkOutput("post_abort.acc_last@3", int'(acc_last), 1);
      if (r == 7) begin
        checkOutput("post_abort.done@7", int'(done), 1);
        checkOutput("post_abort.done_tag@7", int'(done_tag), 8'h77);
      end
      endCycle();
    end

    // Abort and start together while idle: nothing starts.
    dcount = 0;
    for (int r = 0; r < 8; r++) begin
      applyStimulus(r == 0, 8'h99, r == 0);
      if (done) dcount++;
      if (r == 1) begin
        checkOutput("abort_start.mux", int'(mux), 3);
        checkOutput("abort_start.busy", int'(busy), 0);
        checkOutput("abort_start.overrun", int'(overrun), 1);
      end
      endCycle();
    end
    checkOutput("abort_start.done_count", dcount, 0);

    // Reset mid-sequence after the last phase: drops the track and clears overrun.
    dcount = 0;
    for (int r = 0; r < 12; r++) begin
      reset = (r == 4);
      applyStimulus(r == 0, 8'h44, 1'b0);
      if (r >= 5 && done) dcount++;
      if (r == 5) begin
        checkOutput("mid_reset.mux", int'(mux), 3);
        checkOutput("mid_reset.busy", int'(busy), 0);
        checkOutput("mid_reset.overrun", int'(overrun), 0);
      end
      endCycle();
    end
    reset = 1'b0;
    checkOutput("mid_reset.done_count", dcount, 0);

    // Five-phase instance: abort+start while idle, then a normal track.
    target = 1;
    for (int r = 0; r < 4; r++) begin
      applyStimulus(r == 0, 8'h55, r == 0);
      if (r == 1) begin
        checkOutput("p5.abort_start.mux", int'(mux5), 7);
        checkOutput("p5.abort_start.busy", int'(busy5), 0);
      end
      if (done5) checkOutput("p5.abort_start.done", int'(done5), 0);
      endCycle();
    end
    for (int r = 0; r < 9; r++) begin
      applyStimulus(r == 0, 8'hC3, 1'b0);
      if (r >= 1 && r <= 5) begin
        checkOutput($sformatf("p5.mux@%0d", r), int'(mux5), r - 1);
        checkOutput($sformatf("p5.mux_valid@%0d", r), int'(mux_valid5), 1);
        checkOutput($sformatf("p5.acc_clear@%0d", r), int'(acc_clear5), (r == 1) ? 1 : 0);
        checkOutput($sformatf("p5.acc_last@%0d", r), int'(acc_last5), (r == 5) ? 1 : 0);
      end else begin
        checkOutput($sformatf("p5.mux@%0d", r), int'(mux5), 7);
      end
      checkOutput($sformatf("p5.done@%0d", r), int'(done5), (r == 6) ? 1 : 0);
      if (r == 6) checkOutput("p5.done_tag@6", int'(done_tag5), 8'hC3);
      endCycle();
    end
    checkOutput("p5.overrun", int'(overrun5), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
